// File: rtl/seq_det_pkg.sv
// Shared types, reset-default configuration and mask helper for the
// programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int                   MAX_PAT_W   = 32;
  localparam logic [MAX_PAT_W-1:0] DEF_PATTERN = 32'b1011;
  localparam int                   DEF_LEN     = 4;
  localparam logic                 DEF_OVERLAP = 1'b1;
  localparam int                   DEF_TARGET  = 1;
  localparam int                   DEF_TIMEOUT = 0;

  // Ones in the low len bit positions; pattern widths above MAX_PAT_W are unsupported.
  function automatic logic [MAX_PAT_W-1:0] len_mask(input int len);
    logic [MAX_PAT_W-1:0] m;
    for (int i = 0; i < MAX_PAT_W; i++) m[i] = (i < len);
    return m;
  endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Control/CSR and serial-stream bundle between a master and the detector.
interface seq_det_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16,
  parameter int LEN_W = $clog2(PAT_W) + 1
);

  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_target;
  logic [TO_W-1:0]  cfg_timeout;
  logic             start;
  logic             abort;
  logic             din_vld;
  logic             din;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;
  logic             timeout;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
    output start, abort, din_vld, din,
    input  busy, match, match_cnt, done, timeout, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target, cfg_timeout,
    input  start, abort, din_vld, din,
    output busy, match, match_cnt, done, timeout, cfg_err
  );

endinterface

// File: rtl/seq_match_core.sv
// Bit-serial matcher: history shift register, saturating fill count and a
// masked compare of the post-shift history against the pattern.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  // The oldest bit would leave the window before it is ever compared, so only PAT_W-1 are kept.
  logic [PAT_W-2:0]     hist;
  logic [PAT_W-1:0]     hist_nxt;
  logic [LEN_W-1:0]     fill;
  logic [LEN_W-1:0]     fill_nxt;
  logic [MAX_PAT_W-1:0] diff;

  always_comb begin
    hist_nxt = {hist, din};
    fill_nxt = (fill >= LEN_W'(PAT_W)) ? fill : fill + 1'b1;
    diff     = MAX_PAT_W'(hist_nxt ^ pattern) & len_mask(int'(len));
    hit      = shift_en && (fill_nxt >= len) && (diff == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_nxt[PAT_W-2:0];
      fill <= (hit && !overlap) ? '0 : fill_nxt;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller for the serial pattern matcher: config registers, IDLE/RUN
// sequencing, match/timeout counters and registered output pulses.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  seq_det_ctrl_if.slave  bus
);

  localparam int LEN_W = $clog2(PAT_W) + 1;

  state_t           state;
  state_t           state_nxt;
  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_eff;
  logic             overlap_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] target_eff;
  logic [TO_W-1:0]  timeout_q;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] match_cnt_q;
  logic             cfg_legal;
  logic             accept;
  logic             reject;
  logic             shift_en;
  logic             hit;
  logic             match_nxt;
  logic             done_nxt;
  logic             timeout_nxt;
  logic             busy_q;
  logic             match_q;
  logic             done_q;
  logic             timeout_q_pulse;
  logic             cfg_err_q;

  assign shift_en = (state == RUN) && !bus.abort && bus.din_vld;

  seq_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr      (accept),
    .din      (bus.din),
    .pattern  (pattern_q),
    .len      (len_q),
    .overlap  (overlap_q),
    .hit      (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A start in the same cycle as a config write is judged against the new values.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    reject      = 1'b0;
    match_nxt   = 1'b0;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    len_eff     = bus.cfg_we ? bus.cfg_len    : len_q;
    target_eff  = bus.cfg_we ? bus.cfg_target : target_q;
    cfg_legal   = (len_eff >= LEN_W'(2)) && (len_eff <= LEN_W'(PAT_W)) && (target_eff != '0);
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (cfg_legal) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else begin
          match_nxt = hit;
          if (hit && ((match_cnt_q + 1'b1) == target_q)) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else if ((timeout_q != '0) && (to_cnt == (timeout_q - 1'b1))) begin
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q       <= DEF_PATTERN[PAT_W-1:0];
      len_q           <= LEN_W'(DEF_LEN);
      overlap_q       <= DEF_OVERLAP;
      target_q        <= CNT_W'(DEF_TARGET);
      timeout_q       <= TO_W'(DEF_TIMEOUT);
      match_cnt_q     <= '0;
      to_cnt          <= '0;
      busy_q          <= 1'b0;
      match_q         <= 1'b0;
      done_q          <= 1'b0;
      timeout_q_pulse <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.cfg_we) begin
        pattern_q <= bus.cfg_pattern;
        len_q     <= bus.cfg_len;
        overlap_q <= bus.cfg_overlap;
        target_q  <= bus.cfg_target;
        timeout_q <= bus.cfg_timeout;
      end
      if (accept) begin
        match_cnt_q <= '0;
        to_cnt      <= '0;
      end else if (state == RUN) begin
        to_cnt <= to_cnt + 1'b1;
        if (match_nxt) match_cnt_q <= match_cnt_q + 1'b1;
      end
      busy_q          <= (state_nxt == RUN);
      match_q         <= match_nxt;
      done_q          <= done_nxt;
      timeout_q_pulse <= timeout_nxt;
      cfg_err_q       <= reject;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.match     = match_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q_pulse;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_seq_det_ctrl;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int TO_W  = 16;

  logic clk;
  logic rst;

  seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) bus ();

  seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int rst, we, pat, len, ovl, tgt, to, st, ab, vld, d;
    int busy, match, done, tmo, err, cnt;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the run's usable bits are kept as a queue, oldest first.
  bit m_run, m_ovl, m_match, m_done, m_tmo, m_err;
  int m_pat, m_len, m_tgt, m_to, m_cnt, m_cycles;
  bit m_bits[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int pack(int busy, int match, int done, int tmo, int err, int cnt);
    return (busy << 12) | (match << 11) | (done << 10) | (tmo << 9) | (err << 8) | (cnt & 'hFF);
  endfunction

  function automatic int dut_out();
    return int'({bus.busy, bus.match, bus.done, bus.timeout, bus.cfg_err, bus.match_cnt});
  endfunction

  function automatic int model_out();
    return pack(int'(m_run), int'(m_match), int'(m_done), int'(m_tmo), int'(m_err), m_cnt);
  endfunction

  task automatic modelReset();
    m_run = 0; m_pat = 'b1011; m_len = 4; m_ovl = 1; m_tgt = 1; m_to = 0;
    m_cnt = 0; m_cycles = 0; m_bits.delete();
    m_match = 0; m_done = 0; m_tmo = 0; m_err = 0;
  endtask

  task automatic modelStep();
    int val;
    bit hit;
    m_match = 0; m_done = 0; m_tmo = 0; m_err = 0;
    hit = 0;
    if (rst) begin
      modelReset();
    end else if (!m_run) begin
      if (bus.cfg_we) begin
        m_pat = int'(bus.cfg_pattern);
        m_len = int'(bus.cfg_len);
        m_ovl = bus.cfg_overlap;
        m_tgt = int'(bus.cfg_target);
        m_to  = int'(bus.cfg_timeout);
      end
      if (bus.start) begin
        if (m_len >= 2 && m_len <= PAT_W && m_tgt != 0) begin
          m_run = 1; m_cnt = 0; m_cycles = 0; m_bits.delete();
        end else begin
          m_err = 1;
        end
      end
    end else if (bus.abort) begin
      m_run = 0;
    end else begin
      m_cycles++;
      if (bus.din_vld) begin
        m_bits.push_back(bus.din);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        if (m_bits.size() >= m_len) begin
          val = 0;
          for (int i = m_bits.size() - m_len; i < m_bits.size(); i++) val = val * 2 + int'(m_bits[i]);
          hit = (val == (m_pat % (1 << m_len)));
        end
      end
      if (hit) begin
        m_match = 1;
        m_cnt++;
        if (!m_ovl) m_bits.delete();
        if (m_cnt == m_tgt) begin
          m_done = 1;
          m_run  = 0;
        end
      end
      if (m_run && m_to != 0 && m_cycles == m_to) begin
        m_tmo = 1;
        m_run = 0;
      end
    end
  endtask

  task automatic applyStimulus(input int r, input int we, input int pat, input int len, input int ovl,
                               input int tgt, input int to, input int st, input int ab,
                               input int vld, input int d);
    rst             = r[0];
    bus.cfg_we      = we[0];
    bus.cfg_pattern = pat[PAT_W-1:0];
    bus.cfg_len     = len[3:0];
    bus.cfg_overlap = ovl[0];
    bus.cfg_target  = tgt[CNT_W-1:0];
    bus.cfg_timeout = to[TO_W-1:0];
    bus.start       = st[0];
    bus.abort       = ab[0];
    bus.din_vld     = vld[0];
    bus.din         = d[0];
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic modelCheck(input string name);
    checkOutput(name, dut_out(), model_out());
  endtask

  initial begin
    int s_a[4];
    int to_at;
    int done_seen;
    rst = 1'b1;
    bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
    bus.cfg_target = '0; bus.cfg_timeout = '0; bus.start = 0; bus.abort = 0;
    bus.din_vld = 0; bus.din = 0;
    modelReset();

    // rst we pat len ovl tgt to | st ab vld d | busy match done tmo err cnt
    tbl.push_back(vec_t'{1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0});
    tbl.push_back(vec_t'{0,1,'b1011,4,1,3,0, 0,0,0,0, 0,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 1,0,0,0, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,0, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,1,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,0, 1,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,1,0,0,0,2});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,0,1, 1,0,0,0,0,2});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,1,0,0, 0,0,0,0,0,2});
    tbl.push_back(vec_t'{0,1,'b1011,4,0,3,0, 1,0,0,0, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,0, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,1,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,0, 1,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,1,0,0, 0,0,0,0,0,1});
    tbl.push_back(vec_t'{0,1,'b110,3,1,2,0, 1,0,0,0, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,0, 1,1,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,1, 1,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,1,0, 0,1,1,0,0,2});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,2});
    tbl.push_back(vec_t'{0,1,'b1011,1,1,2,0, 1,0,0,0, 0,0,0,0,1,2});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,2});
    tbl.push_back(vec_t'{0,1,'b1011,4,1,0,0, 1,0,0,0, 0,0,0,0,1,2});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,2});
    tbl.push_back(vec_t'{0,1,'b1011,9,1,1,0, 1,0,0,0, 0,0,0,0,1,2});
    tbl.push_back(vec_t'{0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,2});

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].we, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].tgt,
                    tbl[i].to, tbl[i].st, tbl[i].ab, tbl[i].vld, tbl[i].d);
      checkOutput($sformatf("table_%0d", i), dut_out(),
                  pack(tbl[i].busy, tbl[i].match, tbl[i].done, tbl[i].tmo, tbl[i].err, tbl[i].cnt));
    end

    // Timeout of 10 with a non-matching stream.
    to_at = -1;
    done_seen = 0;
    applyStimulus(0,1,'b1011,4,1,1,10, 1,0,0,0);
    modelCheck("timeout_start");
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(0,0,0,0,0,0,0, 0,0,1,0);
      modelCheck($sformatf("timeout_cycle_%0d", k));
      if (bus.timeout && to_at < 0) to_at = k;
      if (bus.done) done_seen = 1;
    end
    checkOutput("timeout_latency", to_at, 10);
    checkOutput("timeout_no_done", done_seen, 0);

    // Config write and start during RUN are ignored.
    s_a = '{1, 0, 1, 1};
    applyStimulus(0,1,'b1011,4,1,1,0, 1,0,0,0);
    modelCheck("run_cfg_start");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0,1,'b0000,4,1,1,0, 1,0,1,s_a[k]);
      modelCheck($sformatf("run_cfg_bit_%0d", k));
    end
    checkOutput("run_cfg_ignored", dut_out(), pack(0,1,1,0,0,1));

    // Abort on the cycle carrying the final matching bit.
    applyStimulus(0,1,'b1011,4,1,1,0, 1,0,0,0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0,0,0,0,0,0,0, 0,0,1,s_a[k]);
      modelCheck($sformatf("abort_bit_%0d", k));
    end
    applyStimulus(0,0,0,0,0,0,0, 0,1,1,1);
    checkOutput("abort_final_bit", dut_out(), pack(0,0,0,0,0,0));
    applyStimulus(0,0,0,0,0,0,0, 0,0,0,0);
    checkOutput("abort_idle", dut_out(), pack(0,0,0,0,0,0));

    // Reset in the middle of a run restores the default configuration.
    applyStimulus(0,1,'b0110,4,1,2,0, 1,0,0,0);
    applyStimulus(0,0,0,0,0,0,0, 0,0,1,0);
    applyStimulus(0,0,0,0,0,0,0, 0,0,1,1);
    modelCheck("rst_pre");
    applyStimulus(1,0,0,0,0,0,0, 0,0,0,0);
    checkOutput("rst_mid_run", dut_out(), pack(0,0,0,0,0,0));
    applyStimulus(0,0,0,0,0,0,0, 1,0,0,0);
    modelCheck("rst_default_start");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0,0,0,0,0,0,0, 0,0,1,s_a[k]);
      modelCheck($sformatf("rst_default_bit_%0d", k));
    end
    checkOutput("rst_default_done", dut_out(), pack(0,1,1,0,0,1));

    // Randomized traffic against the reference model.
    applyStimulus(1,0,0,0,0,0,0, 0,0,0,0);
    modelCheck("random_reset");
    for (int c = 0; c < 1500; c++) begin
      int r, we, pat, len, ovl, tgt, to, st, ab, vld, d;
      r   = ($urandom_range(0, 399) == 0) ? 1 : 0;
      we  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      pat = int'($urandom_range(0, 255));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(2, 5));
      ovl = int'($urandom_range(0, 1));
      tgt = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      to  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(5, 40));
      st  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ab  = ($urandom_range(0, 59) == 0) ? 1 : 0;
      vld = ($urandom_range(0, 3) != 0) ? 1 : 0;
      d   = int'($urandom_range(0, 1));
      applyStimulus(r, we, pat, len, ovl, tgt, to, st, ab, vld, d);
      modelCheck($sformatf("random_%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Programmable serial-pattern detection controller. It configures, arms and sequences a bit-serial pattern matcher, then counts matches against a target and enforces a timeout window.
- Generalises the team's fixed 1011 detectors. Pattern, length and overlap mode are run-time configurable.
- Sits between a control/CSR master (config, start, abort) and a 1-bit serial data stream.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, width of the match counter and the target.
- TO_W, 16, width of the timeout cycle counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  config write strobe; honoured only in IDLE.
- cfg_pattern  in  PAT_W  pattern; bit[len-1] is the first bit in time, bit0 the last.
- cfg_len  in  $clog2(PAT_W)+1  pattern length; legal range 2..PAT_W.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after each match.
- cfg_target  in  CNT_W  number of matches that completes a run; must be nonzero.
- cfg_timeout  in  TO_W  run cycle limit; 0 disables the timeout.
- start  in  1  single-cycle request to begin a run.
- abort  in  1  cancel the run in progress.
- din_vld  in  1  din is valid this cycle.
- din  in  1  serial data bit.
- busy  out  1  high while in RUN.
- match  out  1  one-cycle pulse per detected pattern.
- match_cnt  out  CNT_W  matches in the current or last run.
- done  out  1  one-cycle pulse when match_cnt reaches cfg_target.
- timeout  out  1  one-cycle pulse when the timeout expires.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst=1 at an edge):
  - state = IDLE.
  - All outputs 0; history and fill cleared.
  - Config registers load defaults: pattern = 'b1011, len = 4, overlap = 1, target = 1, timeout = 0.
- State machine: IDLE, RUN.
- IDLE:
  - cfg_we=1 latches all cfg_* fields into the config registers.
  - start=1 with a legal config (len in 2..PAT_W and target != 0):
    - clear match_cnt, history, fill and timeout counter;
    - go to RUN.
  - start=1 with an illegal config: cfg_err pulses the next cycle; stay in IDLE; match_cnt unchanged.
  - If cfg_we and start are both high in the same cycle, start uses the newly written config.
- RUN:
  - cfg_we and start are ignored.
  - On an edge with din_vld=1:
    - hist <= {hist[PAT_W-2:0], din};
    - fill <= min(fill+1, PAT_W).
  - Match condition, evaluated on the post-shift values: fill >= len AND hist[len-1:0] == pattern[len-1:0].
  - Match latency: the match pulse is registered and is high in the cycle after the edge that sampled the final bit.
  - On a match, match_cnt increments (no wrap is possible, since the run ends at target).
    - If overlap = 0, fill is cleared to 0, so bits used by this match are not reused.
    - If overlap = 1, hist and fill are kept.
  - din_vld=0 holds hist and fill; gaps are transparent to matching.
  - When the increment makes match_cnt == target:
    - done pulses in the same cycle as the final match pulse;
    - next state is IDLE; match_cnt holds its value.
  - Timeout counter:
    - increments every RUN cycle, whether or not din_vld is high;
    - when timeout != 0 and the counter reaches timeout-1 with no completion, timeout pulses and next state is IDLE.
  - abort=1: next state is IDLE, and din is ignored that cycle. No match, done or timeout is produced for that cycle; match_cnt holds.
- Simultaneous events, in priority order:
  - rst over everything;
  - abort over completion or timeout;
  - completion (done) over timeout in the same cycle.
- Reset asserted mid-RUN: synchronous return to IDLE with default config; in-flight pulses are dropped.
- busy is registered: high from the cycle after start is accepted until the cycle after done, timeout or abort.

Decomposition:
- Package seq_det_pkg:
  - state enum {IDLE, RUN};
  - reset-default constants (DEF_PATTERN = 'b1011, DEF_LEN = 4, DEF_OVERLAP = 1, DEF_TARGET = 1, DEF_TIMEOUT = 0);
  - helper function for the len-bit mask.
- Sub-module seq_match_core: shift register, saturating fill counter, masked compare and overlap clear. Its inputs are shift_en, clr, din, pattern, len and overlap; its output is a combinational hit.
- seq_det_ctrl holds the config registers, the FSM, the counters and the output pulse registers.

Test Plan:
- Default config, target = 3, overlap = 1, stream 1,0,1,1,0,1,1 -> match pulses after bit 4 and bit 7; match_cnt = 2; busy still high.
- Same stream with overlap = 0 and len = 4 -> one match after bit 4 only; match_cnt = 1.
- Pattern 'b110, len = 3, target = 2, stream 1,1,0,1,1,0 -> done pulse coincident with the second match; busy drops next cycle; match_cnt = 2.
- timeout = 10, target = 1, din held at 0 -> timeout pulses exactly 10 cycles after RUN entry; done never asserts; state returns to IDLE.
- len = 1 then start -> cfg_err pulse; busy stays 0. Then cfg_we during RUN with pattern 'b0000 -> ignored; the original pattern still matches.
- Final matching bit and abort in the same cycle -> no match and no done; IDLE next cycle. rst mid-RUN -> outputs 0 and config back to defaults.
